// File: rtl/tinker_mem_responder.sv
// Data-memory responder for the Tinker core: one outstanding load/store, programmable latency.
// Optional macro TINKER_MEM_ALIGN_CHECK_EN rejects accesses whose addr[2:0] != 0.
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_bmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  bmask_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        accept, commit;
    logic        op_write;
    logic [31:0] op_addr;
    logic [63:0] op_wdata;
    logic [7:0]  op_bmask;
    logic [32:0] last_byte;
    logic        err_c;
    logic [AW-1:0] base;
    logic [63:0] rd_c;

    assign req_ready  = reset && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign commit     = (state != RESP) && (state_nxt == RESP);

    // With zero latency the commit edge is the accept edge, so operands come straight off the port.
    assign op_write = (state == IDLE) ? req_write : write_q;
    assign op_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign op_bmask = (state == IDLE) ? req_bmask : bmask_q;

    assign last_byte = {1'b0, op_addr} + 33'd7;
    assign base      = op_addr[AW-1:0];

`ifdef TINKER_MEM_ALIGN_CHECK_EN
    assign err_c = (last_byte >= 33'(MEM_BYTES)) || (op_addr[2:0] != 3'd0);
`else
    assign err_c = (last_byte >= 33'(MEM_BYTES));
`endif

    always_comb begin
        rd_c = '0;
        for (int k = 0; k < 8; k++) begin
            rd_c[8*k +: 8] = mem[base + AW'(k)];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                bmask_q <= req_bmask;
            end
            if (commit) begin
                resp_err   <= err_c;
                resp_rdata <= (err_c || op_write) ? 64'd0 : rd_c;
            end else if (resp_valid && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; a held reset suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (reset && commit && op_write && !err_c) begin
            for (int k = 0; k < 8; k++) begin
                if (op_bmask[k]) mem[base + AW'(k)] <= op_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Randomized self-checking bench for tinker_mem_responder against a byte-array reference model.
`timescale 1ns/1ps
module tb_tinker_mem_responder;
    localparam int unsigned MEM  = 524288;
    localparam int unsigned MEM0 = 4096;
    localparam int unsigned LAT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 0, req_write = 0, resp_ready = 0;
    logic [31:0] req_addr = 0;
    logic [63:0] req_wdata = 0;
    logic [7:0]  req_bmask = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid0 = 0, req_write0 = 0, resp_ready0 = 0;
    logic [31:0] req_addr0 = 0;
    logic [63:0] req_wdata0 = 0;
    logic [7:0]  req_bmask0 = 0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [63:0] resp_rdata0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [int unsigned];

    always #5 clk = ~clk;

    tinker_mem_responder #(.MEM_BYTES(MEM), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    tinker_mem_responder #(.MEM_BYTES(MEM0), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_bmask(req_bmask0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    // Reference: flat byte store, range/alignment rules applied directly to the request.
    function automatic void model_access(input bit w, input logic [31:0] a, input logic [63:0] d,
                                         input logic [7:0] m, output logic [63:0] rd, output bit e);
        logic [32:0] top;
        top = {1'b0, a} + 33'd7;
        e = (top >= 33'(MEM));
`ifdef TINKER_MEM_ALIGN_CHECK_EN
        if (a[2:0] != 3'd0) e = 1'b1;
`endif
        rd = '0;
        if (!e) begin
            for (int k = 0; k < 8; k++) begin
                if (w) begin
                    if (m[k]) mm[a + k] = d[8*k +: 8];
                end else begin
                    rd[8*k +: 8] = mm.exists(a + k) ? mm[a + k] : 8'h00;
                end
            end
        end
    endfunction

    // Drives one request on dut, returns response and the accept-to-valid edge count.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                          output logic [63:0] rd, output logic e, output int cyc);
        int n;
        resp_ready = 1'($urandom_range(0, 1));
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_bmask = m;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 0;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_timeout addr=%h got resp_valid=%b want 1", a, resp_valid);
        end
        rd = resp_rdata; e = resp_err;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
            checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
            checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
            checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL rst_req_ready0 got %b want 0", req_ready0); end
        end
        reset = 1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready got %b want 1", req_ready); end
        repeat (4) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid got %b want 0", resp_valid); end
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd, erd; logic e; bit ee; int cyc;
        do_req(1, 32'h100, 64'h1122334455667788, 8'hFF, rd, e, cyc);
        model_access(1, 32'h100, 64'h1122334455667788, 8'hFF, erd, ee);
        checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL st_latency got %0d want %0d", cyc, LAT + 1); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL st_err got %b want 0", e); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL st_rdata got %h want 0", rd); end
        do_req(0, 32'h100, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, 32'h100, 64'd0, 8'h00, erd, ee);
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld100 got %h want 1122334455667788", rd); end
        checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL ld_latency got %0d want %0d", cyc, LAT + 1); end
        do_req(0, 32'h101, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, 32'h101, 64'd0, 8'h00, erd, ee);
        checks++; if (e !== ee) begin errors++; $display("FAIL ld101_err got %b want %b", e, ee); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL ld101 got %h want %h", rd, erd); end
    endtask

    task automatic test_bmask();
        logic [63:0] rd, erd; logic e; bit ee; int cyc;
        do_req(1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h81, rd, e, cyc);
        model_access(1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h81, erd, ee);
        do_req(0, 32'h100, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, 32'h100, 64'd0, 8'h00, erd, ee);
        checks++; if (rd !== 64'hFF223344556677FF) begin errors++; $display("FAIL bmask got %h want FF223344556677FF", rd); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL bmask_model got %h want %h", rd, erd); end
    endtask

    task automatic test_back_pressure();
        logic [63:0] erd; bit ee; int n;
        model_access(0, 32'h100, 64'd0, 8'h00, erd, ee);
        resp_ready = 0;
        req_valid = 1; req_write = 0; req_addr = 32'h100; req_bmask = 0;
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1; req_write = 1; req_addr = 32'h108; req_wdata = 64'hA5A5A5A5A5A5A5A5; req_bmask = 8'hFF;
            end
            if (i == 2) req_valid = 0;
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", i, resp_valid); end
            checks++; if (resp_rdata !== erd) begin errors++; $display("FAIL bp_rdata c%0d got %h want %h", i, resp_rdata, erd); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready c%0d got %b want 0", i, req_ready); end
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL bp_drop_rdata got %h want 0", resp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b want 1", req_ready); end
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_ghost_req got %b want 0", resp_valid); end
        end
    endtask

    task automatic test_range();
        logic [63:0] rd, erd; logic e; bit ee; int cyc;
        do_req(1, MEM - 8, 64'h0123456789ABCDEF, 8'hFF, rd, e, cyc);
        model_access(1, MEM - 8, 64'h0123456789ABCDEF, 8'hFF, erd, ee);
        do_req(0, MEM - 7, 64'd0, 8'h00, rd, e, cyc);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rng_ld_err got %b want 1", e); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL rng_ld_rdata got %h want 0", rd); end
        do_req(1, 32'hFFFFFFFC, 64'hDEADBEEFDEADBEEF, 8'hFF, rd, e, cyc);
        model_access(1, 32'hFFFFFFFC, 64'hDEADBEEFDEADBEEF, 8'hFF, erd, ee);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rng_st_err got %b want 1", e); end
        checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL rng_latency got %0d want %0d", cyc, LAT + 1); end
        do_req(0, MEM - 8, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, MEM - 8, 64'd0, 8'h00, erd, ee);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rng_top_err got %b want 0", e); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL rng_top_rdata got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, d; logic e; bit ee, w; int cyc;
        logic [31:0] a; logic [7:0] m;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = MEM - 16 + $urandom_range(0, 15);
            else a = 32'h300 + $urandom_range(0, 63);
            if ((i % 4) == 0) a = {a[31:3], 3'b000};
            d = {$urandom, $urandom};
            m = 8'($urandom);
            do_req(w, a, d, m, rd, e, cyc);
            model_access(w, a, d, m, erd, ee);
            checks++; if (e !== ee) begin errors++; $display("FAIL rnd_err i=%0d a=%h got %b want %b", i, a, e, ee); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_rdata i=%0d a=%h got %h want %h", i, a, rd, erd); end
            checks++; if (cyc != LAT + 1) begin errors++; $display("FAIL rnd_latency i=%0d got %0d want %0d", i, cyc, LAT + 1); end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd, erd; logic e; bit ee; int cyc;
        do_req(1, 32'h200, 64'd0, 8'hFF, rd, e, cyc);
        model_access(1, 32'h200, 64'd0, 8'hFF, erd, ee);
        req_valid = 1; req_write = 1; req_addr = 32'h200; req_wdata = 64'hDEADBEEFCAFEF00D; req_bmask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 0;
        reset = 0;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", req_ready); end
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        do_req(0, 32'h200, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, 32'h200, 64'd0, 8'h00, erd, ee);
        checks++; if (rd !== erd) begin errors++; $display("FAIL abort_data got %h want %h", rd, erd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", e); end
    endtask

    task automatic test_latency0();
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            checks++; if (resp_valid0 !== 1'b0) begin errors++; $display("FAIL l0_pre_valid got %b want 0", resp_valid0); end
            req_valid0 = 1; req_write0 = (pass == 0); req_addr0 = 32'h40;
            req_wdata0 = 64'hCAFEBABE01020304; req_bmask0 = 8'hFF;
            n = 0;
            while (req_ready0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            req_valid0 = 0;
            checks++; if (resp_valid0 !== 1'b1) begin errors++; $display("FAIL l0_latency p%0d got %b want 1", pass, resp_valid0); end
            checks++; if (resp_rdata0 !== ((pass == 0) ? 64'd0 : 64'hCAFEBABE01020304)) begin
                errors++; $display("FAIL l0_rdata p%0d got %h", pass, resp_rdata0);
            end
            resp_ready0 = 1;
            @(posedge clk); #1;
            resp_ready0 = 0;
        end
    endtask

    task automatic test_align();
        logic [63:0] rd, erd; logic e; bit ee; int cyc;
        do_req(0, 32'h104, 64'd0, 8'h00, rd, e, cyc);
        model_access(0, 32'h104, 64'd0, 8'h00, erd, ee);
        checks++; if (e !== ee) begin errors++; $display("FAIL align_err got %b want %b", e, ee); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL align_rdata got %h want %h", rd, erd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_bmask();
        test_back_pressure();
        test_range();
        test_random();
        test_reset_abort();
        test_latency0();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinker_mem_responder.md
Name: tinker_mem_responder

Overview:
- Responder end of the Tinker core's data-memory interface.
- Accepts one load or store request at a time from a core-side initiator over a valid/ready request channel.
- Models a programmable access latency and returns data or a completion on a valid/ready response channel.
- Storage is byte-addressed and little-endian; accesses are 64-bit with per-byte store enables. This lets the pipelined core stall on real memory timing instead of reading combinationally.

Parameters:
- MEM_BYTES, 524288, storage size in bytes; valid addresses are 0..MEM_BYTES-1.
- LATENCY, 2, wait cycles between request accept and response valid, range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  initiator has a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address of the least-significant byte.
- req_wdata  input  64  store data; byte k goes to address req_addr+k.
- req_bmask  input  8  store byte enables; bit k enables byte k. Ignored for loads.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  64  load data, little-endian; 0 for stores and errors.
- resp_err  output  1  request was rejected; no storage change.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- While reset=0:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Storage contents are not altered by reset; simulation initialises storage to zero.
  - Asserting reset mid-transaction aborts the transaction. A store not yet committed is discarded.
- IDLE:
  - req_ready=1 when reset=1.
  - On a clock edge with req_valid&&req_ready, latch write, addr, wdata and bmask, and load the counter with LATENCY.
  - If LATENCY=0, go to RESP. Otherwise go to WAIT.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; when it reaches 1, go to RESP on the next edge.
  - Response valid therefore appears exactly LATENCY+1 cycles after the accept edge.
- Commit, on the edge entering RESP:
  - Range check: error if addr+7 >= MEM_BYTES, computed in 33 bits so there is no wrap-around at 2^32.
  - Error: no storage write, resp_err=1, resp_rdata=0.
  - Load: resp_rdata = {byte[addr+7] .. byte[addr]}, resp_err=0.
  - Store: write each byte k with bmask[k]=1; resp_rdata=0, resp_err=0.
  - Unaligned addresses are legal; a bmask of 0 completes with no write.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid&&resp_ready, go to IDLE. resp_valid, resp_rdata and resp_err drop to 0 on that edge.
  - req_ready=0 in RESP, so there is no same-cycle accept. Minimum throughput is one request per LATENCY+2 cycles.
- resp_ready held high before resp_valid has no effect.
- req_valid is ignored outside IDLE. The initiator must hold the request fields stable until accepted.
- No X on outputs after reset release.

Optional Feature:
- Macro: TINKER_MEM_ALIGN_CHECK_EN.
- Defined: a request with addr[2:0]!=0 is treated as an error at commit: no write, resp_err=1, resp_rdata=0. Timing is identical to a normal request.
- Undefined: unaligned accesses are legal and complete normally.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, then 1 -> all outputs 0 during reset; req_ready=1 on the first cycle after release; resp_valid stays 0 with no requests.
- Store then load, LATENCY=2:
  - Store addr=0x100, wdata=0x1122334455667788, bmask=0xFF -> resp_valid exactly 3 cycles after accept, resp_err=0, resp_rdata=0.
  - Load addr=0x100 -> resp_rdata=0x1122334455667788.
  - Load addr=0x101 -> resp_rdata=0x0011223344556677.
- Byte mask: after the store above, store addr=0x100, wdata=0xFFFFFFFFFFFFFFFF, bmask=0x81 -> load 0x100 returns 0xFF223344556677FF.
- Back-pressure: issue a load, hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable throughout; req_ready=0; a req_valid pulse meanwhile is not accepted. Raise resp_ready -> back to IDLE next edge.
- Range error: load addr=MEM_BYTES-7 -> resp_err=1, rdata=0. Store addr=0xFFFFFFFC -> resp_err=1, no storage byte changes. Load addr=MEM_BYTES-8 -> resp_err=0.
- Reset mid-operation and latency corner: reset=0 while in WAIT for a store to 0x200 -> a later load of 0x200 returns 0. With LATENCY=0, resp_valid is asserted 1 cycle after accept. With TINKER_MEM_ALIGN_CHECK_EN defined, a load of addr=0x104 gives resp_err=1.
